// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: internal word RAM with MEM_WAIT wait states, upstream stall.
// Optional macro MEM_WB_STALL_CNT_EN adds a saturating 32-bit stall-cycle counter output.
module mem_wb_stage #(
   parameter int DATA_DEPTH = 64,
   parameter int MEM_WAIT   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_Ctrl_Jal,
   input  logic        in_Ctrl_RegWrite,
   input  logic        in_Ctrl_MemToReg,
   input  logic        in_Ctrl_MemRead,
   input  logic        in_Ctrl_MemWrite,
   input  logic [4:0]  in_Write_Register,
   input  logic [31:0] in_ALU_Result,
   input  logic [31:0] in_Write_Data,
   output logic        out_Ctrl_Jal,
   output logic        out_Ctrl_RegWrite,
   output logic        out_Ctrl_MemToReg,
   output logic [4:0]  out_Write_Register,
   output logic [31:0] out_ALU_Result,
   output logic [31:0] out_Read_Data,
   output logic        out_Stall,
`ifdef MEM_WB_STALL_CNT_EN
   output logic [31:0] out_Stall_Count,
`endif
   output logic        out_Addr_Error
);

   localparam int AW = $clog2(DATA_DEPTH);
   localparam logic [2:0] WAIT_C = 3'(MEM_WAIT);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        jal_q, jal_d;
   logic        regwrite_q, regwrite_d;
   logic        memtoreg_q, memtoreg_d;
   logic [4:0]  wr_reg_q, wr_reg_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] read_data_q, read_data_d;
   logic        addr_err_q, addr_err_d;
   logic        stall;
   logic        ram_we;
   logic        ram_re;

   logic [31:0] ram_q [DATA_DEPTH];

   logic          mem_op;
   logic          bad_addr;
   logic [AW-1:0] idx;

   assign mem_op   = in_Ctrl_MemRead | in_Ctrl_MemWrite;
   assign idx      = in_ALU_Result[AW+1:2];
   assign bad_addr = (|in_ALU_Result[1:0]) | (|in_ALU_Result[31:AW+2]);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      jal_d       = jal_q;
      regwrite_d  = regwrite_q;
      memtoreg_d  = memtoreg_q;
      wr_reg_d    = wr_reg_q;
      alu_d       = alu_q;
      read_data_d = read_data_q;
      addr_err_d  = addr_err_q;
      stall       = 1'b0;
      ram_we      = 1'b0;
      ram_re      = 1'b0;

      if (state_q == IDLE && mem_op && MEM_WAIT > 0) begin
         stall   = 1'b1;
         state_d = BUSY;
         cnt_d   = 3'd1;
         jal_d = 1'b0; regwrite_d = 1'b0; memtoreg_d = 1'b0;
      end else if (state_q == BUSY && cnt_q < WAIT_C) begin
         stall = 1'b1;
         cnt_d = cnt_q + 3'd1;
         jal_d = 1'b0; regwrite_d = 1'b0; memtoreg_d = 1'b0;
      end else begin
         // Either a plain pass-through or the completion edge of an access
         state_d     = IDLE;
         cnt_d       = 3'd0;
         jal_d       = in_Ctrl_Jal;
         regwrite_d  = in_Ctrl_RegWrite;
         memtoreg_d  = in_Ctrl_MemToReg;
         wr_reg_d    = in_Write_Register;
         alu_d       = in_ALU_Result;
         read_data_d = 32'd0;
         if (mem_op) begin
            if (bad_addr) begin
               addr_err_d = 1'b1;
            end else if (in_Ctrl_MemWrite) begin
               ram_we = 1'b1;
            end else begin
               ram_re = 1'b1;
            end
         end
      end
   end

   assign out_Stall = stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         jal_q       <= 1'b0;
         regwrite_q  <= 1'b0;
         memtoreg_q  <= 1'b0;
         wr_reg_q    <= 5'd0;
         alu_q       <= 32'd0;
         read_data_q <= 32'd0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         jal_q       <= jal_d;
         regwrite_q  <= regwrite_d;
         memtoreg_q  <= memtoreg_d;
         wr_reg_q    <= wr_reg_d;
         alu_q       <= alu_d;
         read_data_q <= ram_re ? ram_q[idx] : read_data_d;
         addr_err_q  <= addr_err_d;
      end
   end

   // Reset wins over a completing store, so an aborted access never writes
   always_ff @(posedge clk) begin
      if (!reset && ram_we) begin
         ram_q[idx] <= in_Write_Data;
      end
   end

`ifdef MEM_WB_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_Stall_Count = stall_cnt_q;
`endif

   assign out_Ctrl_Jal       = jal_q;
   assign out_Ctrl_RegWrite  = regwrite_q;
   assign out_Ctrl_MemToReg  = memtoreg_q;
   assign out_Write_Register = wr_reg_q;
   assign out_ALU_Result     = alu_q;
   assign out_Read_Data      = read_data_q;
   assign out_Addr_Error     = addr_err_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register of the 5-stage MIPS core.
- Consumes the EX/MEM register outputs, performs the data-memory access on an internal word RAM with a configurable wait-state count, and registers the results for write-back.
- Drives a stall to freeze the upstream stages while a multi-cycle access is in progress.

Parameters:
- DATA_DEPTH, 64, number of 32-bit words in the data RAM (power of two, 16..1024).
- MEM_WAIT, 2, wait cycles per load/store (0..7).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_Ctrl_Jal  input  1  jal marker from EX/MEM
- in_Ctrl_RegWrite  input  1  register-write enable from EX/MEM
- in_Ctrl_MemToReg  input  1  write-back select from EX/MEM
- in_Ctrl_MemRead  input  1  load request
- in_Ctrl_MemWrite  input  1  store request
- in_Write_Register  input  5  destination register
- in_ALU_Result  input  32  byte address, or ALU result for non-memory ops
- in_Write_Data  input  32  store data
- out_Ctrl_Jal  output  1  registered jal marker
- out_Ctrl_RegWrite  output  1  registered register-write enable
- out_Ctrl_MemToReg  output  1  registered write-back select
- out_Write_Register  output  5  registered destination register
- out_ALU_Result  output  32  registered ALU result
- out_Read_Data  output  32  registered load data
- out_Stall  output  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM when high
- out_Addr_Error  output  1  sticky misaligned or out-of-range access flag

Behaviour:
- Reset, synchronous: all outputs 0, FSM in IDLE, wait counter 0. RAM contents are not cleared; simulation initialises the RAM to 0.
- Memory operation: MemRead|MemWrite. Word index = in_ALU_Result[31:2].
- Address is bad if in_ALU_Result[1:0] != 0 or the word index >= DATA_DEPTH.
- FSM states: IDLE and BUSY. Counter cnt is 3 bits.
- IDLE, no memory operation:
  - out_Stall=0.
  - Next edge loads all MEM/WB outputs from the inputs; out_Read_Data <= 0.
  - Single-cycle latency.
- IDLE, memory operation, MEM_WAIT=0: the access completes this cycle (see completion).
- IDLE, memory operation, MEM_WAIT>0:
  - out_Stall=1.
  - Next edge: go to BUSY, cnt<=1, MEM/WB loads a bubble.
- BUSY:
  - out_Stall = (cnt < MEM_WAIT).
  - If cnt < MEM_WAIT: cnt<=cnt+1, and MEM/WB loads a bubble.
  - If cnt == MEM_WAIT: completion, then state<=IDLE, cnt<=0.
- Bubble:
  - out_Ctrl_RegWrite, out_Ctrl_MemToReg, out_Ctrl_Jal <= 0.
  - out_Write_Register, out_ALU_Result, out_Read_Data hold their values.
- Completion edge, normal case:
  - Store: RAM[index] <= in_Write_Data, performed exactly once per access.
  - Load: out_Read_Data <= RAM[index], old data.
  - All MEM/WB control and data outputs load from the inputs.
- Completion edge, MemRead and MemWrite both set: treated as a store; out_Read_Data <= 0.
- Completion edge, bad address:
  - The store is suppressed; a load returns 0.
  - out_Addr_Error <= 1 and stays 1 until reset.
  - Control bits still propagate.
- Total access latency is MEM_WAIT+1 cycles. out_Stall is high for exactly MEM_WAIT consecutive cycles per access.
- Upstream holds the inputs stable while out_Stall=1. Back-to-back memory operations each incur the full wait; there is no idle gap.
- Reset while BUSY: the access is aborted, no RAM write occurs, and the FSM returns to IDLE. Reset has priority over completion in the same cycle.

Optional Feature:
- Macro: MEM_WB_STALL_CNT_EN.
- Defined: adds output out_Stall_Count (32 bits).
  - Increments on every edge where out_Stall=1 and reset=0.
  - Saturates at 0xFFFFFFFF.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (DATA_DEPTH=64, MEM_WAIT=2):
- Store: MemWrite=1, ALU_Result=0x10, Write_Data=0xDEADBEEF.
  - Required: out_Stall high 2 cycles, then low; no RAM write before the completion edge.
  - Then load: MemRead=1, MemToReg=1, RegWrite=1, ALU_Result=0x10, Write_Register=8.
  - Required: after 3 edges, out_Read_Data=0xDEADBEEF, out_Ctrl_RegWrite=1, out_Write_Register=8; bubble outputs (RegWrite=0) during the stall.
- R-type: RegWrite=1, ALU_Result=0x1234, Write_Register=3.
  - Required: out_Stall stays 0; one edge later out_ALU_Result=0x1234, out_Write_Register=3, out_Read_Data=0.
- Misaligned store to 0x13 (Write_Data=0x55), then load of 0x10.
  - Required: out_Addr_Error=1 after completion and sticky; the load returns 0xDEADBEEF, i.e. RAM is unchanged.
- Load from 0x100 (index 64, out of range).
  - Required: out_Read_Data=0, out_Addr_Error=1.
- Store 0xAAAA5555 to 0x20, then assert reset during the first BUSY cycle.
  - Required: next edge all outputs 0, out_Stall=0.
  - A following load from 0x20 returns the prior contents (0).
- MEM_WB_STALL_CNT_EN defined, three loads back-to-back.
  - Required: out_Stall_Count=6.
  - Reset clears it to 0.
